nasti_mover_arbiter: RTL and testbench
======================================

Name: nasti_mover_arbiter

Overview:
- Shares one `nasti_data_mover` command port (src/dest/len, valid/ready) between NREQ requesters, e.g. boot loader, SD DMA and debug.
- Round-robin grant; latches one descriptor at a time.
- Rejects descriptors the mover cannot execute (misaligned or zero length) instead of forwarding them.
- Tracks mover completion and returns a one-cycle per-requester done/error response.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 64, address/length width; matches the mover.
- DATA_WIDTH, 64, mover beat width in bits. ADDR_SHIFT = log2(DATA_WIDTH/8) is the alignment bits.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester descriptor valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_src  in  NREQ*ADDR_WIDTH  source byte address, requester i in slice i.
- req_dest  in  NREQ*ADDR_WIDTH  destination byte address.
- req_len  in  NREQ*ADDR_WIDTH  length in bytes.
- resp_valid  out  NREQ  one-cycle completion pulse to the owner.
- resp_err  out  1  qualifies resp_valid: 1 = descriptor rejected, not executed.
- mv_src  out  ADDR_WIDTH  to mover r_src.
- mv_dest  out  ADDR_WIDTH  to mover r_dest.
- mv_len  out  ADDR_WIDTH  to mover r_len.
- mv_valid  out  1  to mover r_valid.
- mv_ready  in  1  from mover r_ready (high when idle; low from the cycle after accept until the transfer ends).
- busy  out  1  high whenever state != IDLE.
- owner  out  $clog2(NREQ)  index of the current owner; valid while busy.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, mv_valid=0, resp_valid=0, resp_err=0, mv_src/dest/len=0, owner=0, seen_low=0.
- Reset is legal mid-transfer: the arbiter returns to IDLE and drops mv_valid. The mover must be reset by the same event; no response is issued for the aborted descriptor.
- State IDLE:
  - Grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready is combinational and one-hot on the grant, only in IDLE.
  - On handshake: latch src/dest/len and owner=i, then check the descriptor.
  - If any of src/dest/len has nonzero bits [ADDR_SHIFT-1:0], or len==0, go to RESP with err=1.
  - Otherwise go to ISSUE.
  - No grant when no req_valid; req_ready stays 0.
- State ISSUE:
  - mv_valid=1 (registered); mv_src/dest/len hold the latched values.
  - On mv_valid & mv_ready: mv_valid<=0, seen_low<=0, go to BUSY.
  - mv_valid never drops before the handshake.
- State BUSY:
  - mv_ready==0 sets seen_low.
  - mv_ready==1 with seen_low==1 means the transfer is complete: go to RESP, err=0.
  - mv_ready==1 before seen_low is ignored. This covers the cycle right after accept if the mover is slow to drop.
- State RESP:
  - resp_valid[owner]=1 and resp_err=err for exactly one cycle.
  - rr_ptr <= (owner+1) mod NREQ, then go to IDLE.
- Latency and throughput:
  - Minimum 2 cycles from accept to a rejection pulse.
  - Next grant no earlier than the cycle after RESP.
  - One descriptor in flight.
- Fairness: a requester holding req_valid is granted within NREQ descriptors.
- Requests arriving while busy wait; req_valid is not required to be sticky but should be held by requesters.
- req_* inputs are sampled only at the handshake; later changes are ignored.
- Simultaneous requests resolve strictly by rr_ptr. rr_ptr advances after both success and reject.
- owner wraps: NREQ-1 -> 0.

Decomposition:
- Package nasti_mover_pkg:
  - typedef mv_desc_t {src, dest, len} of ADDR_WIDTH each.
  - enum arb_state_t {IDLE, ISSUE, BUSY, RESP}.
  - function is_aligned(addr, shift).
- Sub-module rr_arbiter (NREQ, combinational grant from req vector and pointer, one-hot out). It is reusable by other NASTI muxes.

Test Plan:
- Single request: req 1 valid, src=0x1000, dest=0x8000, len=0x800 → one mover handshake with exactly those values; mover drops ready for 40 cycles then raises → resp_valid[1] one cycle, resp_err=0, busy low the cycle after.
- Reject: req 0 with src=0x1004 and, separately, len=0 → no mv_valid ever; resp_valid[0] with resp_err=1 two cycles after accept.
- Contention: all 4 req_valid held, rr_ptr=0 → grant order 0,1,2,3,0; each resp_valid pulses only to its owner.
- Back-pressure: mv_ready held low 10 cycles while idle (mover not accepting) → mv_valid stays 1 with stable fields; handshake on the 11th cycle; no spurious completion.
- Late ready drop: mover keeps mv_ready high 2 cycles after accept, then low 5, then high → exactly one completion, on the final rise.
- Reset mid-BUSY: assert areset while BUSY → mv_valid=0, busy=0, resp_valid=0 immediately; after release, the next request from rr_ptr=0 is granted normally.

Source files
------------

// File: rtl/nasti_mover_pkg.sv
// Shared types for the NASTI data-mover command arbiter: descriptor layout,
// arbiter state encoding and an address alignment helper.
package nasti_mover_pkg;

  localparam int unsigned MV_ADDR_WIDTH = 64;

  typedef struct packed {
    logic [MV_ADDR_WIDTH-1:0] src;
    logic [MV_ADDR_WIDTH-1:0] dest;
    logic [MV_ADDR_WIDTH-1:0] len;
  } mv_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } arb_state_t;

  // True when the low 'shift' bits of addr are all zero.
  function automatic logic is_aligned(input logic [MV_ADDR_WIDTH-1:0] addr,
                                      input int unsigned shift);
    logic [MV_ADDR_WIDTH-1:0] mask;
    mask = (MV_ADDR_WIDTH'(1) << shift) - MV_ADDR_WIDTH'(1);
    return (addr & mask) == '0;
  endfunction

endpackage

// File: rtl/nasti_mover_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after the pointer, wrapping modulo NREQ. Output grant is one-hot or zero.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NREQ);

  // Scan from the pointer position and take the first requester found.
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = IDX_W'((int'(ptr) + off) % NREQ);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/nasti_mover_arbiter.sv
// Shares one nasti_data_mover command port among NREQ requesters. One
// descriptor is in flight at a time; descriptors the mover cannot run are
// answered with an error pulse instead of being forwarded.
module nasti_mover_arbiter
  import nasti_mover_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = MV_ADDR_WIDTH,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_src,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_dest,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_len,
  output logic [NREQ-1:0]            resp_valid,
  output logic                       resp_err,
  output logic [ADDR_WIDTH-1:0]      mv_src,
  output logic [ADDR_WIDTH-1:0]      mv_dest,
  output logic [ADDR_WIDTH-1:0]      mv_len,
  output logic                       mv_valid,
  input  logic                       mv_ready,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    owner
);

  localparam int          IDX_W      = $clog2(NREQ);
  localparam int unsigned ADDR_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  mv_desc_t         desc_q, desc_d;
  logic             err_q, err_d;
  logic             seen_low_q, seen_low_d;
  logic             mv_valid_q, mv_valid_d;

  logic [NREQ-1:0]  grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  mv_desc_t         req_desc_arr [NREQ];
  mv_desc_t         req_desc;
  logic             req_bad;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_desc_arr[i].src  = req_src [i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_desc_arr[i].dest = req_dest[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_desc_arr[i].len  = req_len [i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Pick the granted descriptor and decide whether the mover can execute it.
  always_comb begin
    req_desc = req_desc_arr[grant_idx];
    req_bad  = !is_aligned(req_desc.src,  ADDR_SHIFT) ||
               !is_aligned(req_desc.dest, ADDR_SHIFT) ||
               !is_aligned(req_desc.len,  ADDR_SHIFT) ||
               (req_desc.len == '0);
  end

  // State and datapath registers; reset abandons any descriptor in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      desc_q     <= '0;
      err_q      <= 1'b0;
      seen_low_q <= 1'b0;
      mv_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      desc_q     <= desc_d;
      err_q      <= err_d;
      seen_low_q <= seen_low_d;
      mv_valid_q <= mv_valid_d;
    end
  end

  // Next-state logic: accept, issue, wait for the mover's ready low-then-high.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    desc_d     = desc_q;
    err_d      = err_q;
    seen_low_d = seen_low_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          desc_d  = req_desc;
          owner_d = grant_idx;
          err_d   = req_bad;
          state_d = req_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (mv_valid_q && mv_ready) begin
          seen_low_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (!mv_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mv_valid_d = (state_d == ISSUE);
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready  = (state_q == IDLE) ? grant : '0;
    resp_valid = '0;
    if (state_q == RESP) begin
      resp_valid[owner_q] = 1'b1;
    end
    resp_err = (state_q == RESP) && err_q;
    busy     = (state_q != IDLE);
  end

  assign mv_valid = mv_valid_q;
  assign mv_src   = desc_q.src;
  assign mv_dest  = desc_q.dest;
  assign mv_len   = desc_q.len;
  assign owner    = owner_q;

endmodule

// File: tb/tb_nasti_mover_arbiter.sv
// Directed bench for nasti_mover_arbiter: drives requesters and a hand-played
// mover, with a scoreboard of expected mover commands and responses.
module tb_nasti_mover_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 64;

  typedef struct {
    int idx;
    bit err;
  } respExp_t;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dest;
    logic [AW-1:0] len;
  } descExp_t;

  logic               aclk = 1'b0;
  logic               areset;
  logic [NREQ-1:0]    reqValid;
  logic [NREQ-1:0]    reqReady;
  logic [NREQ*AW-1:0] reqSrc, reqDest, reqLen;
  logic [NREQ-1:0]    respValid;
  logic               respErr;
  logic [AW-1:0]      mvSrc, mvDest, mvLen;
  logic               mvValid, mvReady;
  logic               busy;
  logic [1:0]         owner;

  logic [AW-1:0] srcArr  [NREQ];
  logic [AW-1:0] destArr [NREQ];
  logic [AW-1:0] lenArr  [NREQ];

  respExp_t respQ[$];
  descExp_t mvQ[$];
  int total = 0;
  int bad = 0;
  int rrPtrModel = 0;
  int orderExp [5] = '{0, 1, 2, 3, 0};

  always #5 aclk = ~aclk;

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign reqSrc [i*AW +: AW] = srcArr[i];
    assign reqDest[i*AW +: AW] = destArr[i];
    assign reqLen [i*AW +: AW] = lenArr[i];
  end

  nasti_mover_arbiter #(
    .NREQ(NREQ),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(64)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_src   (reqSrc),
    .req_dest  (reqDest),
    .req_len   (reqLen),
    .resp_valid(respValid),
    .resp_err  (respErr),
    .mv_src    (mvSrc),
    .mv_dest   (mvDest),
    .mv_len    (mvLen),
    .mv_valid  (mvValid),
    .mv_ready  (mvReady),
    .busy      (busy),
    .owner     (owner)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic failNow(input string tag);
    total++;
    bad++;
    $error("[TB] FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic applyStimulus(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input logic [AW-1:0] l);
    srcArr[i]   = s;
    destArr[i]  = d;
    lenArr[i]   = l;
    reqValid[i] = 1'b1;
  endtask

  function automatic int modelGrant();
    for (int off = 0; off < NREQ; off++) begin
      if (reqValid[(rrPtrModel + off) % NREQ]) return (rrPtrModel + off) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit modelBad(input int i);
    return (srcArr[i][2:0] != 3'd0) || (destArr[i][2:0] != 3'd0) ||
           (lenArr[i][2:0] != 3'd0) || (lenArr[i] == '0);
  endfunction

  // Wait for the arbiter to offer a grant, check it, and record what should follow.
  task automatic waitGrant(input bit dropAfter, output int g);
    bit seen = 0;
    respExp_t r;
    descExp_t d;
    g = -1;
    #1;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (k > 0) begin
        @(negedge aclk);
        #1;
      end
      if (reqReady != '0) seen = 1;
    end
    if (!seen) begin
      failNow("grant_timeout");
      return;
    end
    g = modelGrant();
    checkOutput("grant", reqReady, (g < 0) ? 64'd0 : (64'd1 << g));
    if (g < 0) return;
    r.idx = g;
    r.err = modelBad(g);
    respQ.push_back(r);
    if (!r.err) begin
      d.src  = srcArr[g];
      d.dest = destArr[g];
      d.len  = lenArr[g];
      mvQ.push_back(d);
    end
    @(posedge aclk);
    #1;
    if (dropAfter) reqValid[g] = 1'b0;
    checkOutput("busy_after_accept", busy, 1);
    checkOutput("owner", owner, g);
  endtask

  // Play the mover command handshake, optionally stalling with ready low.
  task automatic mvAccept(input int stall);
    bit seen = 0;
    descExp_t e;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge aclk);
      if (mvValid) seen = 1;
    end
    if (!seen) begin
      failNow("mv_valid_timeout");
      return;
    end
    if (mvQ.size() == 0) begin
      failNow("mv_unexpected_cmd");
      return;
    end
    e = mvQ.pop_front();
    checkOutput("mv_src", mvSrc, e.src);
    checkOutput("mv_dest", mvDest, e.dest);
    checkOutput("mv_len", mvLen, e.len);
    if (stall > 0) begin
      mvReady = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(negedge aclk);
        checkOutput("mv_valid_held", mvValid, 1);
        checkOutput("mv_src_held", mvSrc, e.src);
        checkOutput("mv_len_held", mvLen, e.len);
      end
      mvReady = 1'b1;
    end
    @(posedge aclk);
    #1;
  endtask

  // Mover ready profile after accept: high for highAfter cycles, low for lowCycles, then high.
  task automatic transfer(input int highAfter, input int lowCycles);
    for (int k = 0; k < highAfter; k++) begin
      @(posedge aclk);
      #1;
      checkOutput("no_early_resp", respValid, 0);
    end
    mvReady = 1'b0;
    for (int k = 0; k < lowCycles; k++) begin
      @(posedge aclk);
      #1;
      checkOutput("no_resp_while_low", respValid, 0);
    end
    mvReady = 1'b1;
  endtask

  // Wait for a response pulse and compare it with the scoreboard head.
  task automatic waitResp(input int budget, input bit expectNoMv);
    bit seen = 0;
    respExp_t e;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge aclk);
      if (expectNoMv) checkOutput("no_mv_valid", mvValid, 0);
      if (respValid != '0) seen = 1;
    end
    if (!seen) begin
      failNow("resp_timeout");
      return;
    end
    if (respQ.size() == 0) begin
      failNow("resp_unexpected");
      return;
    end
    e = respQ.pop_front();
    checkOutput("resp_valid", respValid, 64'd1 << e.idx);
    checkOutput("resp_err", respErr, e.err);
    rrPtrModel = (e.idx + 1) % NREQ;
    @(negedge aclk);
    checkOutput("resp_one_cycle", respValid, 0);
    checkOutput("idle_after_resp", busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    areset   = 1'b1;
    reqValid = '0;
    mvReady  = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      srcArr[i]  = '0;
      destArr[i] = '0;
      lenArr[i]  = '0;
    end
    repeat (3) @(negedge aclk);
    checkOutput("rst_mv_valid", mvValid, 0);
    checkOutput("rst_resp_valid", respValid, 0);
    checkOutput("rst_resp_err", respErr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_mv_src", mvSrc, 0);
    checkOutput("rst_mv_len", mvLen, 0);
    checkOutput("rst_req_ready", reqReady, 0);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("idle_no_grant", reqReady, 0);

    $display("[TB] single request");
    applyStimulus(1, 64'h1000, 64'h8000, 64'h800);
    waitGrant(1, g);
    srcArr[1] = 64'hFFF0;
    mvAccept(0);
    transfer(0, 40);
    waitResp(4, 0);

    $display("[TB] reject misaligned src");
    applyStimulus(0, 64'h1004, 64'h8000, 64'h800);
    waitGrant(1, g);
    checkOutput("reject_no_mv", mvValid, 0);
    waitResp(1, 1);

    $display("[TB] reject zero length");
    applyStimulus(0, 64'h1000, 64'h8000, 64'h0);
    waitGrant(1, g);
    checkOutput("reject_no_mv", mvValid, 0);
    waitResp(1, 1);

    $display("[TB] back-pressure");
    applyStimulus(2, 64'h2000, 64'h3000, 64'h40);
    waitGrant(1, g);
    mvAccept(10);
    transfer(0, 3);
    waitResp(4, 0);

    $display("[TB] late ready drop");
    applyStimulus(3, 64'h4000, 64'h5000, 64'h100);
    waitGrant(1, g);
    mvAccept(0);
    transfer(2, 5);
    waitResp(4, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      checkOutput("single_completion", respValid, 0);
    end

    $display("[TB] reset mid-transfer");
    applyStimulus(1, 64'h6000, 64'h7000, 64'h80);
    waitGrant(1, g);
    mvAccept(0);
    mvReady = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("busy_mid_transfer", busy, 1);
    areset = 1'b1;
    #1;
    checkOutput("rst_mid_mv_valid", mvValid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_resp_valid", respValid, 0);
    respQ.delete();
    mvQ.delete();
    rrPtrModel = 0;
    mvReady = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    $display("[TB] contention");
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(i, 64'h10000 * (i + 1), 64'h20000 * (i + 1), 64'h100 * (i + 1));
    end
    for (int n = 0; n < 5; n++) begin
      waitGrant(0, g);
      checkOutput("grant_order", owner, orderExp[n]);
      mvAccept(0);
      transfer(0, 2);
      waitResp(4, 0);
    end
    reqValid = '0;
    @(negedge aclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
